// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the pipeline skid-register stage.
//   pipe_state_t        : occupancy of the stage (EMPTY / BUSY / FULL)
//   PIPE_DEFAULT_WIDTH  : default payload width of one pipeline entry
// ---------------------------------------------------------------------------
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // no entry held
      BUSY  = 2'd1,   // main register valid
      FULL  = 2'd2    // main and skid registers valid
   } pipe_state_t;

   localparam int PIPE_DEFAULT_WIDTH = 74;

endpackage

// File: rtl/pipe_data_bank.sv
// ---------------------------------------------------------------------------
// pipe_data_bank
// WIDTH-bit payload register with load enable and synchronous clear.
// Clear wins over load.
// Ports:
//   i_clk   : rising-edge clock
//   i_clr   : synchronous clear to zero
//   i_load  : capture i_d this cycle
//   i_d     : payload in
//   o_q     : registered payload out
// ---------------------------------------------------------------------------
module pipe_data_bank
   import pipe_pkg::*;
#(
   parameter int WIDTH = PIPE_DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_clr)
         r_q <= '0;
      else if (i_load)
         r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg
// One pipeline stage register with valid/ready handshake and a one-entry
// skid buffer. in_ready and out_valid come straight from the state register,
// so the backpressure path is fully registered while upstream can still
// stream at one entry per cycle.
//
// Ports:
//   clk          : rising-edge clock
//   reset        : synchronous, active-high; empties stage, zeroes data
//   flush        : synchronous kill; empties stage, data left as-is
//   in_valid     : upstream presents in_data
//   in_data      : upstream payload
//   in_ready     : stage can accept (state != FULL)
//   out_valid    : out_data holds a valid entry (state != EMPTY)
//   out_data     : head entry payload
//   out_ready    : downstream takes the head this cycle
//   stall_cycles : (PIPE_SKID_PERF_EN only) saturating count of cycles with
//                  out_valid && !out_ready && !flush; cleared by reset only
//
// Build option: define PIPE_SKID_PERF_EN to add the stall counter.
// ---------------------------------------------------------------------------
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH     = PIPE_DEFAULT_WIDTH,
   parameter int CNT_WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
`ifdef PIPE_SKID_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cycles
`endif
);

   if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_chk
      $error("pipe_skid_reg: WIDTH and CNT_WIDTH must be at least 1");
   end

   pipe_state_t      r_state;
   pipe_state_t      w_state_nxt;
   logic             w_accept;
   logic             w_deliver;
   logic             w_main_load;
   logic             w_skid_load;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] w_main_q;
   logic [WIDTH-1:0] w_skid_q;

   assign in_ready  = (r_state != FULL);
   assign out_valid = (r_state != EMPTY);
   assign out_data  = w_main_q;

   assign w_accept  = in_valid  & in_ready;
   assign w_deliver = out_valid & out_ready;

   // Main refills from the skid when draining FULL, else from upstream.
   assign w_main_d  = (r_state == FULL) ? w_skid_q : in_data;

   always_comb begin
      w_state_nxt = r_state;
      w_main_load = 1'b0;
      w_skid_load = 1'b0;
      if (flush) begin
         // Any handshake in the flush cycle is dropped.
         w_state_nxt = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_main_load = 1'b1;
                  w_state_nxt = BUSY;
               end
            end
            BUSY: begin
               if (w_accept && w_deliver) begin
                  w_main_load = 1'b1;
               end else if (w_deliver) begin
                  w_state_nxt = EMPTY;
               end else if (w_accept) begin
                  w_skid_load = 1'b1;
                  w_state_nxt = FULL;
               end
            end
            FULL: begin
               // in_ready is low here, so only a delivery can move us.
               if (w_deliver) begin
                  w_main_load = 1'b1;
                  w_state_nxt = BUSY;
               end
            end
            default: w_state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= EMPTY;
      else
         r_state <= w_state_nxt;
   end

   pipe_data_bank #(.WIDTH(WIDTH)) u_main (
      .i_clk  (clk),
      .i_clr  (reset),
      .i_load (w_main_load),
      .i_d    (w_main_d),
      .o_q    (w_main_q)
   );

   pipe_data_bank #(.WIDTH(WIDTH)) u_skid (
      .i_clk  (clk),
      .i_clr  (reset),
      .i_load (w_skid_load),
      .i_d    (in_data),
      .o_q    (w_skid_q)
   );

`ifdef PIPE_SKID_PERF_EN
   logic [CNT_WIDTH-1:0] r_stall_cnt;
   logic                 w_stall;

   assign w_stall = out_valid & ~out_ready & ~flush;

   // Saturating; flush deliberately leaves the count alone.
   always_ff @(posedge clk) begin
      if (reset)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != {CNT_WIDTH{1'b1}}))
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end

   assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

   localparam int W  = 74;
`ifdef PIPE_SKID_PERF_EN
   localparam int CW = 2;
`else
   localparam int CW = 16;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready = 1'b0;
`ifdef PIPE_SKID_PERF_EN
   logic [CW-1:0] stall_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the stage is a FIFO of capacity two.
   logic [W-1:0] m_q[$];
   bit           m_zero = 1'b0;   // head register known to hold zero
   int           m_stall = 0;

   pipe_skid_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
`ifdef PIPE_SKID_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Advance one clock and update the model; outputs are sampled 1ns later.
   task automatic tick();
      bit acc, dlv;
      acc = in_valid && (m_q.size() < 2);
      dlv = (m_q.size() > 0) && out_ready;
      @(posedge clk);
      if (reset) begin
         m_q.delete();
         m_zero  = 1'b1;
         m_stall = 0;
      end else begin
         if (m_q.size() > 0 && !out_ready && !flush && m_stall < (1 << CW) - 1)
            m_stall++;
         if (flush) begin
            m_q.delete();
            m_zero = 1'b0;
         end else begin
            if (dlv) void'(m_q.pop_front());
            if (acc) begin
               m_q.push_back(in_data);
               m_zero = 1'b0;
            end
         end
      end
      #1;
   endtask

   function automatic logic [W-1:0] rnd_data();
      return {10'($urandom), $urandom, $urandom};
   endfunction

   task automatic idle_inputs();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = rnd_data(); out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 2) idle_inputs();
         tick();
         n_checks++;
         if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", c, out_valid); end
         n_checks++;
         if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data cyc=%0d got=%h exp=0", c, out_data); end
         n_checks++;
         if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=1", c, in_ready); end
`ifdef PIPE_SKID_PERF_EN
         n_checks++;
         if (stall_cycles !== '0) begin n_errors++; $display("FAIL reset_stall cyc=%0d got=%0d exp=0", c, stall_cycles); end
`endif
      end
   endtask

   task automatic test_streaming();
      idle_inputs();
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         in_valid = 1'b1;
         in_data  = W'(k);
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_data !== W'(k)) begin
            n_errors++; $display("FAIL stream_data k=%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, W'(k));
         end
         n_checks++;
         if (in_ready !== 1'b1) begin n_errors++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, in_ready); end
      end
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      idle_inputs();
      in_valid = 1'b1; in_data = W'('hA);
      tick();
      n_checks++;
      if (out_data !== W'('hA) || in_ready !== 1'b1) begin
         n_errors++; $display("FAIL bp_first got d=%h rdy=%b exp d=a rdy=1", out_data, in_ready);
      end
      in_data = W'('hB);
      tick();
      // A third offer while FULL must be refused.
      in_data = W'('hD);
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== W'('hA)) begin
            n_errors++; $display("FAIL bp_full cyc=%0d got rdy=%b v=%b d=%h exp rdy=0 v=1 d=a", c, in_ready, out_valid, out_data);
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      n_checks++;
      if (out_data !== W'('hA)) begin n_errors++; $display("FAIL bp_head got=%h exp=a", out_data); end
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== W'('hB) || in_ready !== 1'b1) begin
         n_errors++; $display("FAIL bp_second got v=%b d=%h rdy=%b exp v=1 d=b rdy=1", out_valid, out_data, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_flush_full();
      idle_inputs();
      in_valid = 1'b1; in_data = W'('hA); tick();
      in_data = W'('hB); tick();
      n_checks++;
      if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_setup got rdy=%b exp=0", in_ready); end
      flush = 1'b1; in_data = W'('hC); out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++; $display("FAIL flush_empty got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_leak cyc=%0d got v=%b d=%h exp v=0", c, out_valid, out_data); end
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      in_valid = 1'b1; in_data = W'('h5); tick();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== W'('h5)) begin
         n_errors++; $display("FAIL rmid_busy got v=%b d=%h exp v=1 d=5", out_valid, out_data);
      end
      reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = W'('h7); out_ready = 1'b1;
      tick();
      idle_inputs();
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
         n_errors++; $display("FAIL rmid_cleared got v=%b d=%h rdy=%b exp v=0 d=0 rdy=1", out_valid, out_data, in_ready);
      end
   endtask

`ifdef PIPE_SKID_PERF_EN
   task automatic test_perf();
      idle_inputs();
      in_valid = 1'b1; in_data = rnd_data(); tick();
      in_valid = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      n_checks++;
      if (stall_cycles !== CW'(3)) begin n_errors++; $display("FAIL perf_sat got=%0d exp=3", stall_cycles); end
      flush = 1'b1; tick(); flush = 1'b0;
      tick();
      n_checks++;
      if (stall_cycles !== CW'(3)) begin n_errors++; $display("FAIL perf_flush got=%0d exp=3", stall_cycles); end
      reset = 1'b1; tick(); reset = 1'b0;
      n_checks++;
      if (stall_cycles !== '0) begin n_errors++; $display("FAIL perf_reset got=%0d exp=0", stall_cycles); end
   endtask
`endif

   task automatic test_random();
      idle_inputs();
      for (int c = 0; c < 600; c++) begin
         reset     = ($urandom_range(0, 79) == 0);
         flush     = ($urandom_range(0, 24) == 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = rnd_data();
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
         n_checks++;
         if (out_valid !== (m_q.size() > 0)) begin
            n_errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", c, out_valid, m_q.size() > 0);
         end
         n_checks++;
         if (in_ready !== (m_q.size() < 2)) begin
            n_errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, m_q.size() < 2);
         end
         if (m_q.size() > 0) begin
            n_checks++;
            if (out_data !== m_q[0]) begin n_errors++; $display("FAIL rnd_out_data cyc=%0d got=%h exp=%h", c, out_data, m_q[0]); end
         end else if (m_zero) begin
            n_checks++;
            if (out_data !== '0) begin n_errors++; $display("FAIL rnd_zero cyc=%0d got=%h exp=0", c, out_data); end
         end
`ifdef PIPE_SKID_PERF_EN
         n_checks++;
         if (stall_cycles !== CW'(m_stall)) begin n_errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", c, stall_cycles, m_stall); end
`endif
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush_full();
      test_reset_mid();
`ifdef PIPE_SKID_PERF_EN
      test_perf();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
